// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and helpers for the MEM/WB half of the RV32IF pipeline.
package mem_wb_pipe_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 6;

    // Bit 5 of a register address selects the float register file.
    localparam logic [RADDR_W-1:0] FREG_BASE = 6'd32;

    // funct3 encodings for loads and stores (bit 2 = unsigned load).
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    // Access size from funct3; unlisted encodings fall back to a full word.
    function automatic acc_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return SZ_BYTE;
            2'd1:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_pipe_lsu_align.sv
// Byte-lane store formatting and load extract/extend for a 32-bit data memory.
module lsu_align
    import mem_wb_pipe_pkg::*;
(
    input  logic [2:0]  i_st_f3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_web,
    output logic [31:0] o_st_di,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_raw,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic        w_ld_signed;

    // Store: replicate data across lanes and build active-low byte enables.
    always_comb begin
        o_st_web = 4'h0;
        o_st_di  = i_st_data;
        case (f3_size(i_st_f3))
            SZ_BYTE: begin
                o_st_web = ~(4'b0001 << i_st_off);
                o_st_di  = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                o_st_web = ~(4'b0011 << {i_st_off[1], 1'b0});
                o_st_di  = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load: pick the addressed byte/half and sign- or zero-extend.
    always_comb begin
        w_ld_signed = ~i_ld_f3[2];
        case (i_ld_off)
            2'd0:    w_ld_byte = i_ld_raw[7:0];
            2'd1:    w_ld_byte = i_ld_raw[15:8];
            2'd2:    w_ld_byte = i_ld_raw[23:16];
            default: w_ld_byte = i_ld_raw[31:24];
        endcase
        w_ld_half = i_ld_off[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
        case (f3_size(i_ld_f3))
            SZ_BYTE: o_ld_data = {{24{w_ld_signed & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_ld_data = {{16{w_ld_signed & w_ld_half[15]}}, w_ld_half};
            default: o_ld_data = i_ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM and WB pipeline registers, data-memory interface, WB forwarding
// selects and load-use hazard detection.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = mem_wb_pipe_pkg::XLEN,
    parameter int unsigned RADDR_W = mem_wb_pipe_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [XLEN-1:0]    alu_out_ex,
    input  logic [XLEN-1:0]    rs2_data_ex,
    input  logic [RADDR_W-1:0] rd_addr_ex,
    input  logic               wb_en_ex,
    input  logic               float_wb_en_ex,
    input  logic               mem_rd_ex,
    input  logic               mem_wr_ex,
    input  logic [2:0]         funct3_ex,
    input  logic [RADDR_W-1:0] rs1_addr_id,
    input  logic [RADDR_W-1:0] rs2_addr_id,
    output logic               dm_ce,
    output logic [3:0]         dm_web,
    output logic [XLEN-1:0]    dm_addr,
    output logic [XLEN-1:0]    dm_di,
    input  logic [XLEN-1:0]    dm_do,
    output logic [RADDR_W-1:0] rd_addr_wb,
    output logic               wb_en_wb,
    output logic               float_wb_en_wb,
    output logic [XLEN-1:0]    alu_out_wb,
    output logic               reg1_sel,
    output logic               reg2_sel,
    output logic               load_use_stall
);

    // MEM stage
    logic [XLEN-1:0]    r_m_alu;
    logic [XLEN-1:0]    r_m_rs2;
    logic [RADDR_W-1:0] r_m_rd;
    logic               r_m_wb_en;
    logic               r_m_fwb_en;
    logic               r_m_load;
    logic               r_m_store;
    logic [2:0]         r_m_f3;

    // WB stage
    logic [XLEN-1:0]    r_w_alu;
    logic [RADDR_W-1:0] r_w_rd;
    logic               r_w_wb_en;
    logic               r_w_fwb_en;
    logic               r_w_load;
    logic [2:0]         r_w_f3;
    logic [1:0]         r_w_off;

    logic [3:0]         w_st_web;
    logic [XLEN-1:0]    w_st_di;
    logic [XLEN-1:0]    w_ld_data;
    logic               w_wb_any;
    logic               w_m_dst_any;

    // Capture the EX result into MEM unless the pipeline is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_alu    <= '0;
            r_m_rs2    <= '0;
            r_m_rd     <= '0;
            r_m_wb_en  <= 1'b0;
            r_m_fwb_en <= 1'b0;
            r_m_load   <= 1'b0;
            r_m_store  <= 1'b0;
            r_m_f3     <= '0;
        end else if (!stall) begin
            r_m_alu    <= alu_out_ex;
            r_m_rs2    <= rs2_data_ex;
            r_m_rd     <= rd_addr_ex;
            r_m_wb_en  <= wb_en_ex;
            r_m_fwb_en <= float_wb_en_ex;
            r_m_load   <= mem_rd_ex;
            r_m_store  <= mem_wr_ex;
            r_m_f3     <= funct3_ex;
        end
    end

    // Advance the MEM entry into WB, keeping the byte offset for load alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_alu    <= '0;
            r_w_rd     <= '0;
            r_w_wb_en  <= 1'b0;
            r_w_fwb_en <= 1'b0;
            r_w_load   <= 1'b0;
            r_w_f3     <= '0;
            r_w_off    <= '0;
        end else if (!stall) begin
            r_w_alu    <= r_m_alu;
            r_w_rd     <= r_m_rd;
            r_w_wb_en  <= r_m_wb_en;
            r_w_fwb_en <= r_m_fwb_en;
            r_w_load   <= r_m_load;
            r_w_f3     <= r_m_f3;
            r_w_off    <= r_m_alu[1:0];
        end
    end

    lsu_align u_lsu_align (
        .i_st_f3   (r_m_f3),
        .i_st_off  (r_m_alu[1:0]),
        .i_st_data (r_m_rs2),
        .o_st_web  (w_st_web),
        .o_st_di   (w_st_di),
        .i_ld_f3   (r_w_f3),
        .i_ld_off  (r_w_off),
        .i_ld_raw  (dm_do),
        .o_ld_data (w_ld_data)
    );

    // Memory request issues only in the cycle the MEM entry actually advances,
    // so a stalled access is deferred rather than repeated.
    always_comb begin
        dm_ce   = (r_m_load | r_m_store) & ~stall;
        dm_web  = (r_m_store & dm_ce) ? w_st_web : 4'hF;
        dm_addr = {r_m_alu[XLEN-1:2], 2'b00};
        dm_di   = w_st_di;
    end

    // WB outputs and forwarding selects; x0 never forwards, f0 does.
    always_comb begin
        rd_addr_wb     = r_w_rd;
        wb_en_wb       = r_w_wb_en;
        float_wb_en_wb = r_w_fwb_en;
        alu_out_wb     = r_w_load ? w_ld_data : r_w_alu;
        w_wb_any       = (r_w_wb_en | r_w_fwb_en) & (r_w_rd != '0);
        reg1_sel       = w_wb_any & (rs1_addr_id == r_w_rd);
        reg2_sel       = w_wb_any & (rs2_addr_id == r_w_rd);
    end

    // A load still in MEM cannot be forwarded yet; request a stall on a match.
    always_comb begin
        w_m_dst_any    = (r_m_wb_en | r_m_fwb_en) & (r_m_rd != '0);
        load_use_stall = r_m_load & w_m_dst_any &
                         ((r_m_rd == rs1_addr_id) | (r_m_rd == rs2_addr_id));
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe.
module tb_mem_wb_pipe;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] alu_out_ex;
    logic [31:0] rs2_data_ex;
    logic [5:0]  rd_addr_ex;
    logic        wb_en_ex;
    logic        float_wb_en_ex;
    logic        mem_rd_ex;
    logic        mem_wr_ex;
    logic [2:0]  funct3_ex;
    logic [5:0]  rs1_addr_id;
    logic [5:0]  rs2_addr_id;
    logic        dm_ce;
    logic [3:0]  dm_web;
    logic [31:0] dm_addr;
    logic [31:0] dm_di;
    logic [31:0] dm_do;
    logic [5:0]  rd_addr_wb;
    logic        wb_en_wb;
    logic        float_wb_en_wb;
    logic [31:0] alu_out_wb;
    logic        reg1_sel;
    logic        reg2_sel;
    logic        load_use_stall;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;
    int wr_base  = 0;

    mem_wb_pipe #(.XLEN(32), .RADDR_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .alu_out_ex     (alu_out_ex),
        .rs2_data_ex    (rs2_data_ex),
        .rd_addr_ex     (rd_addr_ex),
        .wb_en_ex       (wb_en_ex),
        .float_wb_en_ex (float_wb_en_ex),
        .mem_rd_ex      (mem_rd_ex),
        .mem_wr_ex      (mem_wr_ex),
        .funct3_ex      (funct3_ex),
        .rs1_addr_id    (rs1_addr_id),
        .rs2_addr_id    (rs2_addr_id),
        .dm_ce          (dm_ce),
        .dm_web         (dm_web),
        .dm_addr        (dm_addr),
        .dm_di          (dm_di),
        .dm_do          (dm_do),
        .rd_addr_wb     (rd_addr_wb),
        .wb_en_wb       (wb_en_wb),
        .float_wb_en_wb (float_wb_en_wb),
        .alu_out_wb     (alu_out_wb),
        .reg1_sel       (reg1_sel),
        .reg2_sel       (reg2_sel),
        .load_use_stall (load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory writes actually presented to the SRAM at a clock edge.
    always @(posedge clk) begin
        if (dm_ce && dm_web != 4'hF) wr_count <= wr_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic ex_set(input logic [31:0] alu, input logic [31:0] rs2, input logic [5:0] rd,
                          input logic wb, input logic fwb, input logic ld, input logic st,
                          input logic [2:0] f3);
        alu_out_ex     = alu;
        rs2_data_ex    = rs2;
        rd_addr_ex     = rd;
        wb_en_ex       = wb;
        float_wb_en_ex = fwb;
        mem_rd_ex      = ld;
        mem_wr_ex      = st;
        funct3_ex      = f3;
    endtask

    task automatic bubble();
        ex_set(32'h0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        bubble();
        rs1_addr_id = 6'd0;
        rs2_addr_id = 6'd0;
        dm_do = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst_ce", dm_ce, 0);
        chk("rst_web", dm_web, 32'hF);
        chk("rst_addr", dm_addr, 0);
        chk("rst_di", dm_di, 0);
        chk("rst_rd", rd_addr_wb, 0);
        chk("rst_wben", wb_en_wb, 0);
        chk("rst_fwben", float_wb_en_wb, 0);
        chk("rst_wbdata", alu_out_wb, 0);
        chk("rst_sel1", reg1_sel, 0);
        chk("rst_lus", load_use_stall, 0);
        rst = 1'b0;

        // ALU result, two edges to WB, forwarding to rs1/rs2
        ex_set(32'h1234, 32'h0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        rs1_addr_id = 6'd5;
        tick();
        chk("alu_mem_ce", dm_ce, 0);
        chk("alu_not_yet", rd_addr_wb, 0);
        bubble();
        tick();
        chk("alu_rd", rd_addr_wb, 5);
        chk("alu_wben", wb_en_wb, 1);
        chk("alu_data", alu_out_wb, 32'h1234);
        chk("alu_sel1", reg1_sel, 1);
        chk("alu_sel2_off", reg2_sel, 0);
        rs1_addr_id = 6'd6;
        rs2_addr_id = 6'd5;
        #1;
        chk("alu_sel1_miss", reg1_sel, 0);
        chk("alu_sel2", reg2_sel, 1);

        // x0 never forwards
        ex_set(32'h55, 32'h0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        rs1_addr_id = 6'd0;
        rs2_addr_id = 6'd0;
        tick();
        bubble();
        tick();
        chk("x0_data", alu_out_wb, 32'h55);
        chk("x0_sel1", reg1_sel, 0);
        chk("x0_sel2", reg2_sel, 0);

        // f0 forwards
        ex_set(32'h99, 32'h0, 6'd32, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        rs1_addr_id = 6'd32;
        tick();
        bubble();
        tick();
        chk("f0_fwben", float_wb_en_wb, 1);
        chk("f0_sel1", reg1_sel, 1);
        rs1_addr_id = 6'd0;

        // SB at 0x103
        ex_set(32'h103, 32'hAB, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        tick();
        chk("sb_ce", dm_ce, 1);
        chk("sb_web", dm_web, 32'h7);
        chk("sb_di", dm_di, 32'hABABABAB);
        chk("sb_addr", dm_addr, 32'h100);
        // SH at 2, then at 3 (offset bit 0 ignored)
        ex_set(32'h2, 32'h1234CDEF, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        tick();
        chk("sh2_web", dm_web, 32'h3);
        chk("sh2_di", dm_di, 32'hCDEFCDEF);
        ex_set(32'h3, 32'h1234CDEF, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        tick();
        chk("sh3_web", dm_web, 32'h3);
        // SW at 7 (low bits ignored)
        ex_set(32'h7, 32'h1234CDEF, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        tick();
        chk("sw_web", dm_web, 32'h0);
        chk("sw_di", dm_di, 32'h1234CDEF);
        chk("sw_addr", dm_addr, 32'h4);
        bubble();
        tick();
        chk("idle_ce", dm_ce, 0);
        chk("idle_web", dm_web, 32'hF);

        // LB at 2
        ex_set(32'h2, 32'h0, 6'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        chk("lb_ce", dm_ce, 1);
        chk("lb_web", dm_web, 32'hF);
        chk("lb_lus_nomatch", load_use_stall, 0);
        dm_do = 32'h00800000;
        bubble();
        tick();
        chk("lb_data", alu_out_wb, 32'hFFFFFF80);
        chk("lb_rd", rd_addr_wb, 7);
        // LBU at 2
        ex_set(32'h2, 32'h0, 6'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4);
        tick();
        bubble();
        tick();
        chk("lbu_data", alu_out_wb, 32'h00000080);
        // LH at 2
        ex_set(32'h2, 32'h0, 6'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
        tick();
        dm_do = 32'h80010000;
        bubble();
        tick();
        chk("lh_data", alu_out_wb, 32'hFFFF8001);
        // LHU at 0
        ex_set(32'h0, 32'h0, 6'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5);
        tick();
        dm_do = 32'h00008001;
        bubble();
        tick();
        chk("lhu_data", alu_out_wb, 32'h00008001);

        // FLW to f1 (33): load-use in MEM, forward in WB
        ex_set(32'h8, 32'h0, 6'd33, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        rs2_addr_id = 6'd33;
        tick();
        chk("flw_lus", load_use_stall, 1);
        rs2_addr_id = 6'd34;
        #1;
        chk("flw_lus_miss", load_use_stall, 0);
        rs2_addr_id = 6'd33;
        dm_do = 32'h3F800000;
        bubble();
        tick();
        chk("flw_fwben", float_wb_en_wb, 1);
        chk("flw_wben", wb_en_wb, 0);
        chk("flw_rd", rd_addr_wb, 33);
        chk("flw_sel2", reg2_sel, 1);
        chk("flw_data", alu_out_wb, 32'h3F800000);
        chk("flw_lus_gone", load_use_stall, 0);
        rs2_addr_id = 6'd0;

        // Load to x0 raises no hazard
        ex_set(32'h0, 32'h0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
        tick();
        chk("lx0_lus", load_use_stall, 0);
        bubble();
        tick();

        // Store held three cycles in MEM behind an ALU entry in WB
        ex_set(32'hABCD, 32'h0, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        rs1_addr_id = 6'd9;
        tick();
        ex_set(32'h20, 32'hDEADBEEF, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        tick();
        bubble();
        stall = 1'b1;
        wr_base = wr_count;
        #1;
        chk("stl_ce0", dm_ce, 0);
        chk("stl_web0", dm_web, 32'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_ce", dm_ce, 0);
            chk("stl_rd", rd_addr_wb, 9);
            chk("stl_data", alu_out_wb, 32'hABCD);
            chk("stl_sel1", reg1_sel, 1);
        end
        chk("stl_nowrite", wr_count - wr_base, 0);
        stall = 1'b0;
        #1;
        chk("rel_ce", dm_ce, 1);
        chk("rel_web", dm_web, 32'h0);
        chk("rel_di", dm_di, 32'hDEADBEEF);
        chk("rel_addr", dm_addr, 32'h20);
        tick();
        chk("rel_one_write", wr_count - wr_base, 1);
        chk("rel_wb_rd", rd_addr_wb, 0);
        tick();
        chk("rel_still_one", wr_count - wr_base, 1);
        rs1_addr_id = 6'd0;

        // Reset while a store is held in MEM
        ex_set(32'h40, 32'h11, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        tick();
        stall = 1'b1;
        bubble();
        tick();
        wr_base = wr_count;
        rst = 1'b1;
        #1;
        chk("mrst_ce", dm_ce, 0);
        chk("mrst_web", dm_web, 32'hF);
        chk("mrst_addr", dm_addr, 0);
        chk("mrst_di", dm_di, 0);
        chk("mrst_data", alu_out_wb, 0);
        chk("mrst_rd", rd_addr_wb, 0);
        tick();
        rst = 1'b0;
        stall = 1'b0;
        #1;
        chk("post_rst_ce", dm_ce, 0);
        tick();
        tick();
        chk("post_rst_nowrite", wr_count - wr_base, 0);
        chk("post_rst_web", dm_web, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
